// File: rtl/axis_skid_slice.sv
// Two-entry skid-buffer register slice for a valid/ready channel, with a
// saturating count of delivered beats. All outputs are driven from flops.
module axis_skid_slice #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [COUNT_WIDTH-1:0] o_beats
);

    // Encoding chosen so o_valid is bit 0 and o_ready is the inverse of bit 1.
    localparam logic [1:0] StEmpty = 2'b00;
    localparam logic [1:0] StBusy  = 2'b01;
    localparam logic [1:0] StFull  = 2'b11;

    localparam logic [COUNT_WIDTH-1:0] BeatsMax = {COUNT_WIDTH{1'b1}};

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       main_q, main_d;
    logic [WIDTH-1:0]       skid_q, skid_d;
    logic [COUNT_WIDTH-1:0] beats_q, beats_d;
    logic                   in_hs;
    logic                   out_hs;

    assign o_valid = state_q[0];
    assign o_ready = ~state_q[1];
    assign o_data  = main_q;
    assign o_beats = beats_q;

    assign in_hs  = i_valid & o_ready;
    assign out_hs = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        beats_d = beats_q;
        if (i_clear) begin
            state_d = StEmpty;
            beats_d = '0;
        end else begin
            if (out_hs && (beats_q != BeatsMax)) begin
                beats_d = beats_q + COUNT_WIDTH'(1);
            end
            case (state_q)
                StEmpty: begin
                    if (in_hs) begin
                        main_d  = i_data;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (in_hs && out_hs) begin
                        main_d = i_data;
                    end else if (in_hs) begin
                        skid_d  = i_data;
                        state_d = StFull;
                    end else if (out_hs) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_hs) begin
                        main_d  = skid_q;
                        state_d = StBusy;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            beats_q <= beats_d;
        end
    end

endmodule
